inta_cascade_sequencer: RTL and testbench
=========================================

// Module: inta_cascade_sequencer
// PURPOSE
//  Interrupt-acknowledge sequencer for the 8259A-style PIC; feeds and consumes the cascade comparator stage.
//  Counts INTA pulses and drives CAS[2:0] as master. As slave, matches CAS against its own ID.
//  Emits the CALL/vector bytes on the data bus and pulses ISR-set / sequence-done to the in-service logic.
// PARAMETERS
//  SYNC_STAGES  2  flops on inta_n before edge detect (>=2)
// PORTS
//  clk           in   1   system clock, all state on rising edge
//  rst           in   1   asynchronous, active-high reset
//  inta_n        in   1   CPU interrupt acknowledge, active low, asynchronous
//  mode_8086     in   1   1: 2-pulse 8086 sequence; 0: 3-pulse 8080 CALL sequence
//  master        in   1   1: master (SP/EN high); 0: slave
//  sngl          in   1   1: single PIC, no cascade; CAS never driven
//  slave_map     in   8   master ICW3: bit n=1 -> slave on IR n
//  slave_id      in   3   slave ICW3 ID
//  irq_valid     in   1   priority resolver has a pending request
//  irq_level     in   3   highest-priority pending level
//  vec_base      in   5   ICW2 T7..T3 (8086 vector)
//  call_addr     in   16  ICW1/ICW2 CALL address base (8080 mode, interval 4)
//  cas_in        in   3   sampled CAS lines (slave)
//  cas_out       out  3   CAS value to drive
//  cas_oe        out  1   CAS output enable
//  data_out      out  8   data bus byte
//  data_oe       out  1   data bus output enable
//  isr_set       out  1   1-cycle pulse: set ISR bit irq_lvl_q, clear IRR
//  irq_lvl_q     out  3   level frozen at first INTA
//  seq_done      out  1   1-cycle pulse when last INTA rises
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; sync flops load 1 (inta_n inactive).
//  Edges: fall = sync'd inta_n 1->0; rise = 0->1. Every response is registered 1 cycle after edge detect.
//  States: IDLE -> P1 (fall) -> G1 (rise) -> P2 (fall) -> G2 (rise, 8080 only) -> P3 (fall) -> IDLE (rise).
//   In 8086 mode, a rise in P2 returns to IDLE.
//  Entering P1:
//   - freeze irq_lvl_q = irq_valid ? irq_level : 3'd7 (spurious -> IR7).
//   - own = !master | sngl | !slave_map[lvl]   (this device supplies the vector).
//   - Master pulses isr_set once, only if irq_valid. Slave pulses isr_set on P1 entry if cas_in==slave_id.
//  Master CAS: cas_oe=1, cas_out=irq_lvl_q from P1 entry until IDLE, only if master&!sngl&slave_map[lvl];
//   else cas_oe=0, cas_out=0.
//  Slave select: sel latched at P1 entry = (cas_in==slave_id). Unselected slave never drives data.
//   Slave in 8086 mode: P1 drives no data.
//  Data drive: data_oe=1 while in a P state and responding; 0 in G states and IDLE.
//   Responding = (master&own) | (!master&sel).
//  8086 bytes: P1 none (data_oe=0); P2 = {vec_base, irq_lvl_q}.
//  8080 bytes: P1 = 8'hCD (master only, always, even when cascaded);
//   P2 = {call_addr[7:5], irq_lvl_q, 2'b00}; P3 = call_addr[15:8].
//  seq_done pulses on the final rise (P2 in 8086, P3 in 8080). irq_lvl_q holds its value until the next P1.
//  Mid-sequence change of mode/master/slave_map: ignored until IDLE (latched at P1 entry).
//  A fall and a rise in the same cycle cannot occur (>=SYNC_STAGES spacing).
//   Glitch shorter than 1 cycle: may be missed; no partial state.
//  Async reset in any state: immediate return to IDLE, outputs 0, no seq_done.
// TESTING
//  Master 8086, slave_map=0, vec_base=5'h10, irq_level=3 valid:
//   2 INTA -> isr_set once at P1, data P2=8'h83, seq_done after 2nd rise.
//  Master 8086, slave_map=8'h08, level 3: cas_oe=1 cas_out=3 through P1..P2; data_oe stays 0.
//  Slave 8086, slave_id=3, cas_in=3, vec_base=5'h18, level 5: data P2=8'hC5.
//   Repeat with cas_in=2 -> data_oe never 1.
//  Master 8080, call_addr=16'h12E0, level 2: bytes CD, E8, 12; seq_done after 3rd rise.
//  irq_valid=0 at P1: irq_lvl_q=7, no isr_set, vector uses 7.
//   Assert rst during P2 -> all outputs 0 at once, state IDLE.

Source files
------------

// File: rtl/inta_cascade_sequencer.sv
// rtl/inta_cascade_sequencer.sv - INTA pulse sequencer with cascade drive/select for an 8259A-style PIC
//
// Purpose: counts CPU interrupt-acknowledge pulses, drives CAS[2:0] as a cascaded
// master, matches CAS against its own ID as a slave, and places the CALL/vector
// bytes on the data bus. Pulses isr_set at the first INTA and seq_done at the last.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   inta_n              asynchronous CPU acknowledge, active low
//   mode_8086           1: two-pulse 8086 sequence, 0: three-pulse 8080 CALL sequence
//   master, sngl        device role; sngl means no cascade at all
//   slave_map           master ICW3, bit n marks a slave on IR n
//   slave_id            slave ICW3 ID
//   irq_valid/irq_level highest-priority pending request from the resolver
//   vec_base, call_addr vector base (8086) and CALL address base (8080)
//   cas_in              sampled CAS lines (slave)
//   cas_out/cas_oe      CAS value and enable (master)
//   data_out/data_oe    data bus byte and enable
//   isr_set             1-cycle pulse: set ISR bit irq_lvl_q
//   irq_lvl_q           level frozen at first INTA
//   seq_done            1-cycle pulse on the final INTA rise

module inta_cascade_sequencer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inta_n,
  input  logic        mode_8086,
  input  logic        master,
  input  logic        sngl,
  input  logic [7:0]  slave_map,
  input  logic [2:0]  slave_id,
  input  logic        irq_valid,
  input  logic [2:0]  irq_level,
  input  logic [4:0]  vec_base,
  input  logic [15:0] call_addr,
  input  logic [2:0]  cas_in,
  output logic [2:0]  cas_out,
  output logic        cas_oe,
  output logic [7:0]  data_out,
  output logic        data_oe,
  output logic        isr_set,
  output logic [2:0]  irq_lvl_q,
  output logic        seq_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_P1,
    S_G1,
    S_P2,
    S_G2,
    S_P3
  } state_t;

  // Synchroniser and edge detector; all flops rest at 1 so reset never looks like a fall.
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_inta_prev;
  logic                   w_fall;
  logic                   w_rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync      <= '1;
      r_inta_prev <= 1'b1;
    end else begin
      r_sync      <= {r_sync[SYNC_STAGES-2:0], inta_n};
      r_inta_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_fall = r_inta_prev & ~r_sync[SYNC_STAGES-1];
  assign w_rise = ~r_inta_prev & r_sync[SYNC_STAGES-1];

  // Sequence state and the per-sequence context captured at P1 entry.
  state_t     r_state;
  logic       r_mode86;
  logic       r_master;
  logic       r_drive;   // this master drives CAS for a cascaded slave
  logic       r_own;     // this device supplies the vector bytes
  logic       r_sel;     // slave addressed by CAS at first INTA
  logic [2:0] r_lvl;

  logic [2:0] r_cas_out;
  logic       r_cas_oe;
  logic [7:0] r_data;
  logic       r_data_oe;
  logic       r_isr_set;
  logic       r_seq_done;

  state_t     w_state_nxt;
  logic       w_mode86_nxt;
  logic       w_master_nxt;
  logic       w_drive_nxt;
  logic       w_own_nxt;
  logic       w_sel_nxt;
  logic [2:0] w_lvl_nxt;
  logic [2:0] w_cas_out_nxt;
  logic       w_cas_oe_nxt;
  logic [7:0] w_data_nxt;
  logic       w_data_oe_nxt;
  logic       w_isr_nxt;
  logic       w_done_nxt;

  logic [2:0] w_lvl_new;
  logic       w_map_bit;
  logic       w_cas_match;
  logic       w_resp;

  // A missing request acknowledges as spurious IR7.
  assign w_lvl_new   = irq_valid ? irq_level : 3'd7;
  assign w_map_bit   = slave_map[w_lvl_new];
  assign w_cas_match = (cas_in == slave_id);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_mode86   <= 1'b0;
      r_master   <= 1'b0;
      r_drive    <= 1'b0;
      r_own      <= 1'b0;
      r_sel      <= 1'b0;
      r_lvl      <= 3'd0;
      r_cas_out  <= 3'd0;
      r_cas_oe   <= 1'b0;
      r_data     <= 8'd0;
      r_data_oe  <= 1'b0;
      r_isr_set  <= 1'b0;
      r_seq_done <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_mode86   <= w_mode86_nxt;
      r_master   <= w_master_nxt;
      r_drive    <= w_drive_nxt;
      r_own      <= w_own_nxt;
      r_sel      <= w_sel_nxt;
      r_lvl      <= w_lvl_nxt;
      r_cas_out  <= w_cas_out_nxt;
      r_cas_oe   <= w_cas_oe_nxt;
      r_data     <= w_data_nxt;
      r_data_oe  <= w_data_oe_nxt;
      r_isr_set  <= w_isr_nxt;
      r_seq_done <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_mode86_nxt = r_mode86;
    w_master_nxt = r_master;
    w_drive_nxt  = r_drive;
    w_own_nxt    = r_own;
    w_sel_nxt    = r_sel;
    w_lvl_nxt    = r_lvl;
    w_isr_nxt    = 1'b0;
    w_done_nxt   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_fall) begin
          w_state_nxt  = S_P1;
          w_mode86_nxt = mode_8086;
          w_master_nxt = master;
          w_lvl_nxt    = w_lvl_new;
          w_drive_nxt  = master & ~sngl & w_map_bit;
          w_own_nxt    = ~master | sngl | ~w_map_bit;
          w_sel_nxt    = w_cas_match;
          w_isr_nxt    = master ? irq_valid : w_cas_match;
        end
      end
      S_P1: if (w_rise) w_state_nxt = S_G1;
      S_G1: if (w_fall) w_state_nxt = S_P2;
      S_P2: begin
        if (w_rise) begin
          if (r_mode86) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_G2;
          end
        end
      end
      S_G2: if (w_fall) w_state_nxt = S_P3;
      S_P3: begin
        if (w_rise) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Outputs are derived from the state being entered so they register together with it.
    w_resp        = w_master_nxt ? w_own_nxt : w_sel_nxt;
    w_data_oe_nxt = 1'b0;
    w_data_nxt    = 8'd0;
    case (w_state_nxt)
      S_P1: begin
        // The CALL opcode always comes from the master, cascaded or not.
        if (!w_mode86_nxt && w_master_nxt) begin
          w_data_oe_nxt = 1'b1;
          w_data_nxt    = 8'hCD;
        end
      end
      S_P2: begin
        if (w_resp) begin
          w_data_oe_nxt = 1'b1;
          w_data_nxt    = w_mode86_nxt ? {vec_base, w_lvl_nxt}
                                       : {call_addr[7:5], w_lvl_nxt, 2'b00};
        end
      end
      S_P3: begin
        if (w_resp) begin
          w_data_oe_nxt = 1'b1;
          w_data_nxt    = call_addr[15:8];
        end
      end
      default: begin
        w_data_oe_nxt = 1'b0;
        w_data_nxt    = 8'd0;
      end
    endcase

    w_cas_oe_nxt  = (w_state_nxt != S_IDLE) & w_drive_nxt;
    w_cas_out_nxt = w_cas_oe_nxt ? w_lvl_nxt : 3'd0;
  end

  assign cas_out   = r_cas_out;
  assign cas_oe    = r_cas_oe;
  assign data_out  = r_data;
  assign data_oe   = r_data_oe;
  assign isr_set   = r_isr_set;
  assign irq_lvl_q = r_lvl;
  assign seq_done  = r_seq_done;

endmodule

// File: tb/tb_inta_cascade_sequencer.sv
// tb/tb_inta_cascade_sequencer.sv - self-checking bench for inta_cascade_sequencer

module tb_inta_cascade_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        inta_n;
  logic        mode_8086;
  logic        master;
  logic        sngl;
  logic [7:0]  slave_map;
  logic [2:0]  slave_id;
  logic        irq_valid;
  logic [2:0]  irq_level;
  logic [4:0]  vec_base;
  logic [15:0] call_addr;
  logic [2:0]  cas_in;
  logic [2:0]  cas_out;
  logic        cas_oe;
  logic [7:0]  data_out;
  logic        data_oe;
  logic        isr_set;
  logic [2:0]  irq_lvl_q;
  logic        seq_done;

  int total = 0;
  int bad   = 0;

  inta_cascade_sequencer #(.SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .inta_n    (inta_n),
    .mode_8086 (mode_8086),
    .master    (master),
    .sngl      (sngl),
    .slave_map (slave_map),
    .slave_id  (slave_id),
    .irq_valid (irq_valid),
    .irq_level (irq_level),
    .vec_base  (vec_base),
    .call_addr (call_addr),
    .cas_in    (cas_in),
    .cas_out   (cas_out),
    .cas_oe    (cas_oe),
    .data_out  (data_out),
    .data_oe   (data_oe),
    .isr_set   (isr_set),
    .irq_lvl_q (irq_lvl_q),
    .seq_done  (seq_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Pulse-level model: inta_n seen through the synchroniser latency, counting
  // acknowledge pulses and deriving the bus behaviour from pulse number.
  bit         q1, q2, q3;
  int         np;
  bit         in_pulse;
  bit         m_mode, m_master, m_drive, m_own, m_sel;
  logic [2:0] m_lvl;
  bit         e_isr, e_done;

  initial begin
    q1 = 1; q2 = 1; q3 = 1; np = 0; in_pulse = 0;
    m_mode = 0; m_master = 0; m_drive = 0; m_own = 0; m_sel = 0; m_lvl = 0;
    e_isr = 0; e_done = 0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        q1 = 1; q2 = 1; q3 = 1; np = 0; in_pulse = 0; m_lvl = 0;
        m_drive = 0; e_isr = 0; e_done = 0;
      end else begin
        e_isr  = 0;
        e_done = 0;
        if (q3 && !q2) begin
          if (np == 0) begin
            m_mode   = mode_8086;
            m_master = master;
            m_lvl    = irq_valid ? irq_level : 3'd7;
            m_drive  = master && !sngl && slave_map[m_lvl];
            m_own    = !master || sngl || !slave_map[m_lvl];
            m_sel    = (cas_in == slave_id);
            e_isr    = master ? irq_valid : (cas_in == slave_id);
          end
          np++;
          in_pulse = 1;
        end else if (!q3 && q2 && np != 0) begin
          in_pulse = 0;
          if (np == (m_mode ? 2 : 3)) begin
            np     = 0;
            e_done = 1;
          end
        end
        q3 = q2; q2 = q1; q1 = inta_n;
      end
    end
  end

  // Recorded DUT activity per sequence, checked against hand-computed literals.
  logic [7:0] bytes[$];
  int         isr_cnt, done_cnt;
  bit         cas_seen;
  logic [2:0] cas_val;
  bit         prev_oe = 0;

  initial begin
    logic [7:0] e_data;
    bit         e_doe, resp;
    forever begin
      @(negedge clk);
      resp  = m_master ? m_own : m_sel;
      e_doe = 0;
      e_data = 8'd0;
      if (in_pulse && np != 0) begin
        if (np == 1 && !m_mode && m_master) begin
          e_doe = 1; e_data = 8'hCD;
        end else if (np == 2 && resp) begin
          e_doe = 1;
          e_data = m_mode ? {vec_base, m_lvl} : {call_addr[7:5], m_lvl, 2'b00};
        end else if (np == 3 && resp) begin
          e_doe = 1; e_data = call_addr[15:8];
        end
      end
      chk("data_oe",   data_oe,   e_doe);
      chk("data_out",  data_out,  e_data);
      chk("cas_oe",    cas_oe,    (np != 0) && m_drive);
      chk("cas_out",   cas_out,   ((np != 0) && m_drive) ? m_lvl : 3'd0);
      chk("isr_set",   isr_set,   e_isr);
      chk("seq_done",  seq_done,  e_done);
      chk("irq_lvl_q", irq_lvl_q, m_lvl);
      if (data_oe && !prev_oe) bytes.push_back(data_out);
      prev_oe = data_oe;
      if (isr_set) isr_cnt++;
      if (seq_done) done_cnt++;
      if (cas_oe) begin
        cas_seen = 1;
        cas_val  = cas_out;
      end
    end
  end

  task automatic clear_rec();
    @(posedge clk);
    bytes.delete();
    isr_cnt  = 0;
    done_cnt = 0;
    cas_seen = 0;
    cas_val  = 3'd0;
  endtask

  task automatic pulse();
    @(negedge clk) inta_n = 1'b0;
    repeat (4) @(negedge clk);
    inta_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic run_seq(input int n);
    clear_rec();
    for (int i = 0; i < n; i++) pulse();
    repeat (3) @(negedge clk);
  endtask

  task automatic check_seq(input string nm, input int nb, input logic [7:0] b0,
                           input logic [7:0] b1, input logic [7:0] b2,
                           input int nisr, input int ndone);
    logic [7:0] exp_b[3];
    exp_b[0] = b0; exp_b[1] = b1; exp_b[2] = b2;
    chk({nm, "_nbytes"}, bytes.size(), nb);
    for (int i = 0; i < nb && i < bytes.size(); i++)
      chk({nm, "_byte"}, bytes[i], exp_b[i]);
    chk({nm, "_isr_cnt"}, isr_cnt, nisr);
    chk({nm, "_done_cnt"}, done_cnt, ndone);
  endtask

  initial begin
    rst = 1'b1; inta_n = 1'b1; mode_8086 = 1'b1; master = 1'b1; sngl = 1'b0;
    slave_map = 8'h00; slave_id = 3'd0; irq_valid = 1'b1; irq_level = 3'd3;
    vec_base = 5'h10; call_addr = 16'h0000; cas_in = 3'd0;
    repeat (3) @(negedge clk);
    chk("rst_data_oe", data_oe, 1'b0);
    chk("rst_cas_oe", cas_oe, 1'b0);
    chk("rst_lvl", irq_lvl_q, 3'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Master 8086, no cascade.
    run_seq(2);
    check_seq("m86", 1, 8'h83, 8'h00, 8'h00, 1, 1);
    chk("m86_cas_seen", cas_seen, 1'b0);
    chk("m86_lvl_hold", irq_lvl_q, 3'd3);

    // Master 8086 with a slave on IR3: drives CAS, supplies no data.
    slave_map = 8'h08;
    run_seq(2);
    check_seq("m86c", 0, 8'h00, 8'h00, 8'h00, 1, 1);
    chk("m86c_cas_seen", cas_seen, 1'b1);
    chk("m86c_cas_val", cas_val, 3'd3);

    // Slave 8086 selected, then unselected.
    master = 1'b0; slave_map = 8'h00; slave_id = 3'd3; cas_in = 3'd3;
    vec_base = 5'h18; irq_level = 3'd5;
    run_seq(2);
    check_seq("s86", 1, 8'hC5, 8'h00, 8'h00, 1, 1);
    cas_in = 3'd2;
    run_seq(2);
    check_seq("s86n", 0, 8'h00, 8'h00, 8'h00, 0, 1);

    // Master 8080 CALL; role/mode changes after the first pulse are ignored.
    master = 1'b1; mode_8086 = 1'b0; call_addr = 16'h12E0; irq_level = 3'd2;
    clear_rec();
    pulse();
    mode_8086 = 1'b1; slave_map = 8'hFF;
    pulse();
    pulse();
    repeat (3) @(negedge clk);
    check_seq("m80", 3, 8'hCD, 8'hE8, 8'h12, 1, 1);
    chk("m80_cas_seen", cas_seen, 1'b0);
    slave_map = 8'h00;

    // Spurious acknowledge goes to IR7.
    mode_8086 = 1'b1; vec_base = 5'h10; irq_valid = 1'b0;
    run_seq(2);
    check_seq("spur", 1, 8'h87, 8'h00, 8'h00, 0, 1);
    chk("spur_lvl", irq_lvl_q, 3'd7);
    irq_valid = 1'b1; irq_level = 3'd3;

    // Reset in P2 clears everything immediately.
    clear_rec();
    pulse();
    @(negedge clk) inta_n = 1'b0;
    repeat (4) @(negedge clk);
    chk("p2_data_oe", data_oe, 1'b1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_data_oe", data_oe, 1'b0);
    chk("arst_data", data_out, 8'h00);
    chk("arst_isr", isr_set, 1'b0);
    chk("arst_lvl", irq_lvl_q, 3'd0);
    chk("arst_done", seq_done, 1'b0);
    @(negedge clk) inta_n = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("arst_no_done", done_cnt, 0);

    // After reset a fresh sequence starts at P1.
    run_seq(2);
    check_seq("post", 1, 8'h83, 8'h00, 8'h00, 1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
